// File: rtl/risc_v_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - funct3 size/sign encodings (RV32I loads/stores)
//   - responder FSM state enum
//   - legality and alignment helper functions
package risc_v_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Reserved encodings, plus the unsigned variants, which only make sense for loads.
    function automatic logic is_illegal_f3(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus between a data-memory initiator (master) and responder (slave).
//   req_*  : valid/ready request channel (we, byte addr, wdata, funct3)
//   resp_* : valid/ready response channel (rdata, err)
interface data_mem_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [DATA_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [FUNCT3_WIDTH-1:0] req_funct3;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder_load_store_align.sv
// load_store_align: combinational byte-lane steering for a little-endian 32-bit RAM.
//   we_i, funct3_i, lane_i : access type, size/sign, addr[1:0]
//   wdata_i  -> be_o, wdata_o : per-lane write enables and replicated store data
//   rword_i  -> rdata_o       : aligned RAM word -> extended load data
//   err_o                     : illegal funct3 or misaligned access
module load_store_align
    import risc_v_mem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    logic [31:0] rshift;

    assign err_o  = is_illegal_f3(funct3_i, we_i) || is_misaligned(funct3_i, lane_i);
    assign rshift = rword_i >> {lane_i, 3'b000};

    // Store data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = '0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << lane_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
        if (!we_i || err_o) begin
            be_o = 4'b0000;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{rshift[7]}}, rshift[7:0]};
            F3_H:    rdata_o = {{16{rshift[15]}}, rshift[15:0]};
            F3_W:    rdata_o = rword_i;
            F3_BU:   rdata_o = {24'b0, rshift[7:0]};
            F3_HU:   rdata_o = {16'b0, rshift[15:0]};
            default: rdata_o = '0;
        endcase
        if (we_i || err_o) begin
            rdata_o = '0;
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data-memory responder with a byte-wide RAM.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset (RAM contents are not cleared)
//   bus   : data_mem_if slave (request in, response out)
// Transaction: IDLE --accept--> WAIT (WAIT_STATES cycles) --> RESP --resp_ready--> IDLE.
// Stores commit and load data is sampled on the edge that enters RESP.
module data_mem_responder
    import risc_v_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int FUNCT3_WIDTH = 3,
    parameter int WAIT_STATES  = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    data_mem_if.slave bus
);
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int CNT_W   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [FUNCT3_WIDTH-1:0] f3_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [7:0]              mem_q [DEPTH];

    logic                    accept;
    logic                    commit;
    logic                    we_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic [FUNCT3_WIDTH-1:0] f3_s;
    logic [31:0]             rword;
    logic [3:0]              be;
    logic [31:0]             wdata_al;
    logic [31:0]             ld_data;
    logic                    ld_err;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    // With WAIT_STATES==0 the commit edge is the accept edge, so the live request
    // must feed the datapath while IDLE; otherwise the captured copy does.
    assign we_s    = (state_q == S_IDLE) ? bus.req_we                      : we_q;
    assign addr_s  = (state_q == S_IDLE) ? bus.req_addr[ADDR_WIDTH-1:0]    : addr_q;
    assign wdata_s = (state_q == S_IDLE) ? bus.req_wdata                   : wdata_q;
    assign f3_s    = (state_q == S_IDLE) ? bus.req_funct3                  : f3_q;

    assign rword = {mem_q[{addr_s[ADDR_WIDTH-1:2], 2'd3}],
                    mem_q[{addr_s[ADDR_WIDTH-1:2], 2'd2}],
                    mem_q[{addr_s[ADDR_WIDTH-1:2], 2'd1}],
                    mem_q[{addr_s[ADDR_WIDTH-1:2], 2'd0}]};

    load_store_align u_align (
        .we_i     (we_s),
        .funct3_i (f3_s),
        .lane_i   (addr_s[1:0]),
        .wdata_i  (wdata_s),
        .rword_i  (rword),
        .be_o     (be),
        .wdata_o  (wdata_al),
        .rdata_o  (ld_data),
        .err_o    (ld_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WS_LOAD);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            rdata_d = ld_data;
            err_d   = ld_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr[ADDR_WIDTH-1:0];
                wdata_q <= bus.req_wdata;
                f3_q    <= bus.req_funct3;
            end
        end
    end

    // RAM has no reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[{addr_s[ADDR_WIDTH-1:2], 2'(i)}] <= wdata_al[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    localparam int WS    = 2;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_if #(.DATA_WIDTH(32), .FUNCT3_WIDTH(3)) bus ();

    data_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .FUNCT3_WIDTH(3), .WAIT_STATES(WS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mm [DEPTH];

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h01010101) ^ 32'h5A5AA5A5;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic mdl_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        if ((addr % nbytes(f3)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] addr, input logic [2:0] f3);
        int a = int'(addr % DEPTH);
        int n = nbytes(f3);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[(a + i) % DEPTH];
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic mdl_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        int a = int'(addr % DEPTH);
        for (int i = 0; i < nbytes(f3); i++) mm[(a + i) % DEPTH] = wd[8*i +: 8];
    endtask

    // ---------------- per-cycle compare process ----------------
    bit          busy = 0;
    bit          after_rst = 0;
    int          cyc = 0;
    int          due = 0;
    logic        c_we;
    logic [31:0] c_addr, c_wd;
    logic [2:0]  c_f3;
    logic [31:0] e_rd;
    logic        e_err;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            busy      = 0;
            after_rst = 1;
        end else begin
            if (after_rst) begin
                check("reset_rdata", bus.resp_rdata, 32'h0);
                check1("reset_err", bus.resp_err, 1'b0);
                after_rst = 0;
            end
            check1("req_ready", bus.req_ready, !busy);
            check1("resp_valid", bus.resp_valid, busy && cyc >= due);
            if (busy && cyc >= due) begin
                check("resp_rdata", bus.resp_rdata, e_rd);
                check1("resp_err", bus.resp_err, e_err);
            end
            if (busy) begin
                if (cyc >= due && bus.resp_ready) busy = 0;
            end else if (bus.req_valid) begin
                c_we   = bus.req_we;
                c_addr = bus.req_addr;
                c_wd   = bus.req_wdata;
                c_f3   = bus.req_funct3;
                e_err  = mdl_err(c_we, c_addr, c_f3);
                e_rd   = (e_err || c_we) ? 32'h0 : mdl_load(c_addr, c_f3);
                busy   = 1;
                due    = cyc + WS + 1;
            end
            // Store becomes visible on the edge that ends the cycle before the response.
            if (busy && cyc == due - 1 && c_we && !e_err) mdl_store(c_addr, c_wd, c_f3);
        end
    end

    // ---------------- driver ----------------
    bit rand_rr = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rr) bus.resp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input bit chk, input logic [31:0] exp_rd,
                       input logic exp_err);
        bit got = 0;
        int lat = 0;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_funct3 = f3;
        bus.req_valid  = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1;
        end
        if (!got) begin
            check1("accept_timeout", 1'b0, 1'b1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) got = 1;
        end
        if (!got) begin
            check1("resp_timeout", 1'b0, 1'b1);
            return;
        end
        if (chk) begin
            check("lit_latency", 32'(lat), 32'(WS + 1));
            check("lit_rdata", bus.resp_rdata, exp_rd);
            check1("lit_err", bus.resp_err, exp_err);
        end
        got = bus.resp_ready;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (bus.resp_ready) got = 1;
        end
        if (!got) check1("resp_ready_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit got;
        logic [31:0] a;
        logic [2:0]  f;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = '0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check1("lit_reset_ready", bus.req_ready, 1'b1);
        check1("lit_reset_valid", bus.resp_valid, 1'b0);
        check("lit_reset_rdata", bus.resp_rdata, 32'h0);
        check1("lit_reset_err", bus.resp_err, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH / 4; i++) txn(1'b1, 32'(i * 4), pat(i), 3'b010, 0, 0, 0);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 3'b010, 1, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 32'h13, 32'h0, 3'b000, 1, 32'hFFFFFFDE, 1'b0);
        txn(1'b0, 32'h13, 32'h0, 3'b100, 1, 32'h000000DE, 1'b0);
        txn(1'b0, 32'h12, 32'h0, 3'b001, 1, 32'hFFFFDEAD, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 3'b101, 1, 32'h0000BEEF, 1'b0);
        txn(1'b1, 32'h11, 32'h12345677, 3'b000, 1, 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 3'b010, 1, 32'hDEAD77EF, 1'b0);
        txn(1'b0, 32'h02, 32'h0, 3'b010, 1, 32'h0, 1'b1);
        txn(1'b1, 32'h01, 32'hFFFFFFFF, 3'b001, 1, 32'h0, 1'b1);
        txn(1'b0, 32'h00, 32'h0, 3'b011, 1, 32'h0, 1'b1);
        txn(1'b1, 32'h04, 32'hFFFFFFFF, 3'b100, 1, 32'h0, 1'b1);
        txn(1'b0, 32'h00, 32'h0, 3'b010, 1, 32'h5A5AA5A5, 1'b0);
        txn(1'b0, 32'h04, 32'h0, 3'b010, 1, 32'h5B5BA4A4, 1'b0);
        txn(1'b1, 32'h240, 32'hCAFEF00D, 3'b010, 1, 32'h0, 1'b0);
        txn(1'b0, 32'h40, 32'h0, 3'b010, 1, 32'hCAFEF00D, 1'b0);
        txn(1'b1, 32'h1FE, 32'h0000A55A, 3'b001, 1, 32'h0, 1'b0);
        txn(1'b0, 32'hFFFFFFFE, 32'h0, 3'b001, 1, 32'hFFFFA55A, 1'b0);

        // Response held back: outputs stay put and a new request is ignored.
        bus.resp_ready = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_funct3 = 3'b010;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        check1("lit_hold_accept", bus.req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.req_addr = 32'h20;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.resp_valid) got = 1;
        end
        check1("lit_hold_resp_seen", got, 1'b1);
        for (int n = 0; n < 5; n++) begin
            check1("lit_hold_valid", bus.resp_valid, 1'b1);
            check("lit_hold_rdata", bus.resp_rdata, 32'hDEAD77EF);
            check1("lit_hold_ready", bus.req_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset while a store to 0x20 is in WAIT: the store is dropped.
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h11111111;
        bus.req_funct3 = 3'b010;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        check1("lit_rstwait_accept", bus.req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check1("lit_rstwait_ready", bus.req_ready, 1'b1);
        check1("lit_rstwait_valid", bus.resp_valid, 1'b0);
        @(posedge clk);
        #1;
        txn(1'b0, 32'h20, 32'h0, 3'b010, 1, 32'h5252ADAD, 1'b0);

        // Randomized traffic with random back-pressure.
        rand_rr = 1;
        for (int k = 0; k < 300; k++) begin
            a = $urandom;
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) != 0 && (f == 3'd3 || f >= 3'd6)) f = 3'b010;
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'b01) a[0] = 1'b0;
                if (f[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            txn(1'($urandom_range(0, 1)), a, $urandom, f, 0, 0, 0);
        end
        rand_rr = 0;
        @(posedge clk);
        #2;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
